parity3_serial_checker: RTL

PARITY3_SERIAL_CHECKER -- requirements
Module: parity3_serial_checker

---
 rtl/parity3_pkg.sv | 13 +
 rtl/parity3_serial_checker.sv | 81 ++++++++
 2 files changed

// File: rtl/parity3_pkg.sv
// Shared definitions for the 3+1 bit serial even-parity frame checker.
package parity3_pkg;

    typedef enum logic [1:0] {
        S_A = 2'd0,
        S_B = 2'd1,
        S_C = 2'd2,
        S_P = 2'd3
    } state_t;

    localparam int FRAME_LEN = 4;

endpackage

// File: rtl/parity3_serial_checker.sv
// Purpose: deserialise a,b,c,p frames and flag odd parity; err counter under `PARITY3_ERR_CNT_EN.
// Latency: out_valid/data_out/parity_err registered one cycle after the p bit is accepted.
// Backpressure: none; in_valid=0 simply stalls the frame, clr aborts it.
module parity3_serial_checker
    import parity3_pkg::*;
#(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 in_valid,
    input  logic                 in_bit,
    output logic [2:0]           data_out,
    output logic                 out_valid,
    output logic                 parity_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    state_t     state_q;
    state_t     state_d;
    logic [2:0] shift_q;
    logic       accept;
    logic       frame_done;
    logic       frame_err;

    // clr beats a simultaneous in_valid: that bit is dropped.
    assign accept     = in_valid & ~clr;
    assign frame_done = accept & (state_q == S_P);
    assign frame_err  = ^{shift_q, in_bit};

    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = S_A;
        end else if (in_valid) begin
            case (state_q)
                S_A:     state_d = S_B;
                S_B:     state_d = S_C;
                S_C:     state_d = S_P;
                default: state_d = S_A;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_A;
            shift_q    <= 3'b000;
            data_out   <= 3'b000;
            out_valid  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            state_q   <= state_d;
            out_valid <= frame_done;
            if (clr) begin
                shift_q <= 3'b000;
            end else if (accept && (state_q != S_P)) begin
                shift_q <= {shift_q[1:0], in_bit};
            end
            if (frame_done) begin
                data_out   <= shift_q;
                parity_err <= frame_err;
            end
        end
    end

`ifdef PARITY3_ERR_CNT_EN
    // Updated on the same edge as out_valid so the count is current while the pulse is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (frame_done && frame_err && (err_cnt != {ERR_CNT_W{1'b1}})) begin
            err_cnt <= err_cnt + ERR_CNT_W'(1);
        end
    end
`else
    assign err_cnt = '0;
`endif

endmodule
